// File: rtl/ace_ccu_snoop_resp_tracker.sv
// Tracks outstanding snoops per response port and releases each snoop's conflict-manager
// address once its response (and any snoop data) has fully completed.
module ace_ccu_snoop_resp_tracker #(
    parameter int unsigned NoRespPorts   = 2,
    parameter int unsigned MaxSnoopTrans = 4,
    parameter int unsigned AxiAddrWidth  = 64,
    parameter int unsigned CmAddrWidth   = 32,
    parameter int unsigned BlockOffset   = 6
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NoRespPorts-1:0]                   ac_valid_i,
    input  logic [NoRespPorts-1:0]                   ac_ready_i,
    input  logic [NoRespPorts-1:0][AxiAddrWidth-1:0] ac_addr_i,
    output logic [NoRespPorts-1:0]                   ac_stall_o,
    input  logic [NoRespPorts-1:0]                   cr_valid_i,
    input  logic [NoRespPorts-1:0]                   cr_ready_i,
    input  logic [NoRespPorts-1:0]                   cr_data_transfer_i,
    input  logic [NoRespPorts-1:0]                   cd_valid_i,
    input  logic [NoRespPorts-1:0]                   cd_ready_i,
    input  logic [NoRespPorts-1:0]                   cd_last_i,
    output logic [NoRespPorts-1:0]                   cm_x_req_o,
    output logic [NoRespPorts-1:0][CmAddrWidth-1:0]  cm_x_addr_o,
    output logic [NoRespPorts-1:0]                   err_o
);
    localparam int unsigned PtrWidth = $clog2(MaxSnoopTrans);
    localparam int unsigned CntWidth = PtrWidth + 1;

    // state | meaning
    // RESP  | waiting for the snoop response of the head entry
    // DATA  | response announced data; waiting for the last CD beat
    typedef enum logic {
        RESP = 1'b0,
        DATA = 1'b1
    } state_e;

    for (genvar p = 0; p < NoRespPorts; p++) begin : g_port
        logic [CmAddrWidth-1:0] mem_q [MaxSnoopTrans];
        logic [PtrWidth-1:0]    wptr_q, rptr_q;
        logic [CntWidth-1:0]    count_q;
        logic [CmAddrWidth-1:0] addr_q;
        logic                   req_q, err_q;
        state_e                 state_q, state_d;
        logic                   ac_hs, cr_hs, cd_hs;
        logic                   full, empty, push, pop, err_set;

        assign ac_hs = ac_valid_i[p] & ac_ready_i[p];
        assign cr_hs = cr_valid_i[p] & cr_ready_i[p];
        assign cd_hs = cd_valid_i[p] & cd_ready_i[p];
        assign full  = (count_q == CntWidth'(MaxSnoopTrans));
        assign empty = (count_q == '0);

        always_comb begin
            state_d = state_q;
            pop     = 1'b0;
            err_set = 1'b0;
            unique case (state_q)
                RESP: begin
                    if (cd_hs) err_set = 1'b1;
                    if (cr_hs) begin
                        if (empty)                       err_set = 1'b1;
                        else if (cr_data_transfer_i[p])  state_d = DATA;
                        else                             pop     = 1'b1;
                    end
                end
                DATA: begin
                    if (cr_hs) err_set = 1'b1;
                    if (cd_hs && cd_last_i[p]) begin
                        pop     = 1'b1;
                        state_d = RESP;
                    end
                end
                default: state_d = RESP;
            endcase
            // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal.
            push = ac_hs && (!full || pop);
            if (ac_hs && full && !pop) err_set = 1'b1;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) state_q <= RESP;
            else         state_q <= state_d;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
                addr_q  <= '0;
                req_q   <= 1'b0;
                err_q   <= 1'b0;
                for (int i = 0; i < MaxSnoopTrans; i++) mem_q[i] <= '0;
            end else begin
                req_q <= pop;
                if (err_set) err_q <= 1'b1;
                if (push) begin
                    mem_q[wptr_q] <= ac_addr_i[p][BlockOffset +: CmAddrWidth];
                    wptr_q        <= wptr_q + 1'b1;
                end
                if (pop) begin
                    addr_q <= mem_q[rptr_q];
                    rptr_q <= rptr_q + 1'b1;
                end
                if (push && !pop)      count_q <= count_q + 1'b1;
                else if (pop && !push) count_q <= count_q - 1'b1;
            end
        end

        assign ac_stall_o[p]  = full;
        assign cm_x_req_o[p]  = req_q;
        assign cm_x_addr_o[p] = addr_q;
        assign err_o[p]       = err_q;
    end
endmodule

// File: tb/tb_ace_ccu_snoop_resp_tracker.sv
// Scoreboard bench: a reference model predicts each release pulse (address and cycle)
// when the completing handshake is driven; a monitor pops and compares on every pulse.
module tb_ace_ccu_snoop_resp_tracker;
    localparam int NP = 2, DEPTH = 4, AW = 64, CW = 32, BO = 6;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [NP-1:0]          ac_valid_i, ac_ready_i, ac_stall_o;
    logic [NP-1:0][AW-1:0]  ac_addr_i;
    logic [NP-1:0]          cr_valid_i, cr_ready_i, cr_data_transfer_i;
    logic [NP-1:0]          cd_valid_i, cd_ready_i, cd_last_i;
    logic [NP-1:0]          cm_x_req_o, err_o;
    logic [NP-1:0][CW-1:0]  cm_x_addr_o;

    typedef struct {
        logic [CW-1:0] addr;
        int            due;
    } exp_t;

    exp_t          exp_q [NP][$];
    logic [CW-1:0] mdl_q [NP][$];
    bit            mdl_data [NP];
    bit            mdl_err  [NP];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_fail   = 0;

    ace_ccu_snoop_resp_tracker #(
        .NoRespPorts(NP), .MaxSnoopTrans(DEPTH), .AxiAddrWidth(AW),
        .CmAddrWidth(CW), .BlockOffset(BO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ac_valid_i(ac_valid_i), .ac_ready_i(ac_ready_i), .ac_addr_i(ac_addr_i),
        .ac_stall_o(ac_stall_o),
        .cr_valid_i(cr_valid_i), .cr_ready_i(cr_ready_i),
        .cr_data_transfer_i(cr_data_transfer_i),
        .cd_valid_i(cd_valid_i), .cd_ready_i(cd_ready_i), .cd_last_i(cd_last_i),
        .cm_x_req_o(cm_x_req_o), .cm_x_addr_o(cm_x_addr_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            for (int p = 0; p < NP; p++) begin
                if (cm_x_req_o[p]) begin
                    if (exp_q[p].size() == 0) begin
                        check($sformatf("spurious_pulse_p%0d", p), cm_x_req_o[p], 1'b0);
                    end else begin
                        exp_t e;
                        e = exp_q[p].pop_front();
                        check($sformatf("pulse_addr_p%0d", p), cm_x_addr_o[p], e.addr);
                        check($sformatf("pulse_cycle_p%0d", p), cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic model_step(input logic [NP-1:0] acv, input logic [NP-1:0][AW-1:0] addr,
                              input logic [NP-1:0] crv, input logic [NP-1:0] dt,
                              input logic [NP-1:0] cdv, input logic [NP-1:0] cdl);
        for (int p = 0; p < NP; p++) begin
            bit   pop;
            exp_t e;
            pop = 1'b0;
            if (!mdl_data[p]) begin
                if (cdv[p]) mdl_err[p] = 1'b1;
                if (crv[p]) begin
                    if (mdl_q[p].size() == 0) mdl_err[p] = 1'b1;
                    else if (dt[p])           mdl_data[p] = 1'b1;
                    else                      pop = 1'b1;
                end
            end else begin
                if (crv[p]) mdl_err[p] = 1'b1;
                if (cdv[p] && cdl[p]) begin
                    pop         = 1'b1;
                    mdl_data[p] = 1'b0;
                end
            end
            if (pop) begin
                e.addr = mdl_q[p].pop_front();
                e.due  = cyc + 1;
                exp_q[p].push_back(e);
            end
            if (acv[p]) begin
                if (mdl_q[p].size() < DEPTH) mdl_q[p].push_back(CW'(addr[p] >> BO));
                else                         mdl_err[p] = 1'b1;
            end
        end
    endtask

    task automatic drive(input logic [NP-1:0] acv, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [NP-1:0] crv, input logic [NP-1:0] dt,
                         input logic [NP-1:0] cdv, input logic [NP-1:0] cdl);
        ac_valid_i         = acv;
        ac_addr_i[0]       = a0;
        ac_addr_i[1]       = a1;
        cr_valid_i         = crv;
        cr_data_transfer_i = dt;
        cd_valid_i         = cdv;
        cd_last_i          = cdl;
        model_step(acv, ac_addr_i, crv, dt, cdv, cdl);
        @(posedge clk_i);
        #1;
        ac_valid_i         = '0;
        cr_valid_i         = '0;
        cr_data_transfer_i = '0;
        cd_valid_i         = '0;
        cd_last_i          = '0;
        for (int p = 0; p < NP; p++) begin
            check($sformatf("stall_p%0d", p), ac_stall_o[p], mdl_q[p].size() == DEPTH);
            check($sformatf("err_p%0d", p), err_o[p], mdl_err[p]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive('0, '0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        rst_ni             = 1'b0;
        ac_ready_i         = '1;
        cr_ready_i         = '1;
        cd_ready_i         = '1;
        ac_valid_i         = '0;
        ac_addr_i          = '0;
        cr_valid_i         = '0;
        cr_data_transfer_i = '0;
        cd_valid_i         = '0;
        cd_last_i          = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_stall", ac_stall_o, 2'b00);
        check("rst_req", cm_x_req_o, 2'b00);
        check("rst_err", err_o, 2'b00);
        check("rst_addr0", cm_x_addr_o[0], 32'h0);
        rst_ni = 1'b1;

        // plain response without data
        drive(2'b01, 64'h1040, '0, '0, '0, '0, '0);
        drive('0, '0, '0, 2'b01, '0, '0, '0);
        check("basic_req", cm_x_req_o, 2'b01);
        check("basic_addr", cm_x_addr_o[0], 32'h41);
        idle(2);
        check("idle_req", cm_x_req_o, 2'b00);
        check("idle_addr_hold", cm_x_addr_o[0], 32'h41);

        // response with four data beats
        drive(2'b01, 64'h80, '0, '0, '0, '0, '0);
        drive('0, '0, '0, 2'b01, 2'b01, '0, '0);
        repeat (3) begin
            drive('0, '0, '0, '0, '0, 2'b01, '0);
            check("data_nolast_req", cm_x_req_o, 2'b00);
        end
        drive('0, '0, '0, '0, '0, 2'b01, 2'b01);
        check("data_last_req", cm_x_req_o, 2'b01);
        check("data_last_addr", cm_x_addr_o[0], 32'h2);

        // fill to depth, then push and pop in the same cycle
        for (int i = 1; i <= DEPTH; i++) drive(2'b01, 64'(i) * 64'h1000, '0, '0, '0, '0, '0);
        check("full_stall", ac_stall_o[0], 1'b1);
        drive(2'b01, 64'h5000, '0, 2'b01, '0, '0, '0);
        check("full_pushpop_stall", ac_stall_o[0], 1'b1);
        check("full_pushpop_err", err_o[0], 1'b0);
        repeat (DEPTH) drive('0, '0, '0, 2'b01, '0, '0, '0);
        check("drained_stall", ac_stall_o[0], 1'b0);
        idle(1);

        // both ports release in the same cycle
        drive(2'b11, 64'hABC0, 64'hDEF00, '0, '0, '0, '0);
        drive('0, '0, '0, 2'b11, '0, '0, '0);
        check("dual_req", cm_x_req_o, 2'b11);
        check("dual_addr0", cm_x_addr_o[0], 32'h2AF);
        check("dual_addr1", cm_x_addr_o[1], 32'h37BC);
        idle(1);

        // overflow on port 0 drops the fifth snoop
        for (int i = 1; i <= DEPTH + 1; i++) drive(2'b01, 64'(i) * 64'h40, '0, '0, '0, '0, '0);
        check("overflow_err", err_o, 2'b01);
        repeat (DEPTH) drive('0, '0, '0, 2'b01, '0, '0, '0);
        idle(2);

        // CR while waiting for data on port 1
        drive(2'b10, '0, 64'h7C0, '0, '0, '0, '0);
        drive('0, '0, '0, 2'b10, 2'b10, '0, '0);
        drive('0, '0, '0, 2'b10, '0, '0, '0);
        check("cr_in_data_err", err_o, 2'b11);
        drive('0, '0, '0, '0, '0, 2'b10, 2'b10);
        check("cr_in_data_release", cm_x_addr_o[1], 32'h1F);
        idle(1);

        // reset with entries outstanding
        for (int i = 1; i <= 3; i++) drive(2'b11, 64'(i) * 64'h100, 64'(i) * 64'h200, '0, '0, '0, '0);
        rst_ni = 1'b0;
        #2;
        check("midrst_stall", ac_stall_o, 2'b00);
        check("midrst_req", cm_x_req_o, 2'b00);
        check("midrst_err", err_o, 2'b00);
        check("midrst_addr0", cm_x_addr_o[0], 32'h0);
        check("midrst_addr1", cm_x_addr_o[1], 32'h0);
        for (int p = 0; p < NP; p++) begin
            mdl_q[p].delete();
            mdl_data[p] = 1'b0;
            mdl_err[p]  = 1'b0;
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // empty-FIFO CR on port 0, CD in RESP on port 1
        drive('0, '0, '0, 2'b01, '0, 2'b10, '0);
        check("post_rst_err", err_o, 2'b11);
        check("post_rst_req", cm_x_req_o, 2'b00);
        idle(3);
        check("err_sticky", err_o, 2'b11);
        drive(2'b01, 64'h2000, '0, '0, '0, '0, '0);
        drive('0, '0, '0, 2'b01, '0, '0, '0);
        check("post_rst_release", cm_x_addr_o[0], 32'h80);
        idle(2);

        for (int p = 0; p < NP; p++)
            check($sformatf("pending_pulses_p%0d", p), exp_q[p].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ace_ccu_snoop_resp_tracker.md
ACE_CCU_SNOOP_RESP_TRACKER -- requirements
Module: ace_ccu_snoop_resp_tracker

Interface
REQ-001 Parameter NoRespPorts, default 2, number of snooped response ports.
REQ-002 Parameter MaxSnoopTrans, default 4, outstanding snoops per port (FIFO depth, power of two, >=2).
REQ-003 Parameter AxiAddrWidth, default 64, snoop address width.
REQ-004 Parameter CmAddrWidth, default 32, conflict-manager address width.
REQ-005 Parameter BlockOffset, default 6; cm address is ac_addr[BlockOffset +: CmAddrWidth].
REQ-006 clk_i  input  1  single clock, rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 ac_valid_i  input  NoRespPorts  snoop address valid per port.
REQ-009 ac_ready_i  input  NoRespPorts  snoop address ready per port.
REQ-010 ac_addr_i  input  NoRespPorts x AxiAddrWidth  snoop address per port.
REQ-011 ac_stall_o  output  NoRespPorts  port tracker full; upstream SHALL gate ac_valid with it.
REQ-012 cr_valid_i / cr_ready_i  input  NoRespPorts each  snoop response handshake.
REQ-013 cr_data_transfer_i  input  NoRespPorts  CR.resp[0]; response carries CD data.
REQ-014 cd_valid_i / cd_ready_i / cd_last_i  input  NoRespPorts each  snoop data handshake, last beat.
REQ-015 cm_x_req_o  output  NoRespPorts  one-cycle release pulse toward conflict manager.
REQ-016 cm_x_addr_o  output  NoRespPorts x CmAddrWidth  address released with cm_x_req_o.
REQ-017 err_o  output  NoRespPorts  sticky protocol-error flag.

Function
REQ-018 Per port, an in-order FIFO SHALL store cm address of every accepted snoop (ac_valid_i & ac_ready_i).
REQ-019 ac_stall_o[p] SHALL be 1 exactly when FIFO p holds MaxSnoopTrans entries (combinational from count).
REQ-020 AC handshake while full SHALL be dropped and set err_o[p].
REQ-021 Per-port FSM, states RESP and DATA; reset state RESP.
REQ-022 RESP: CR handshake with cr_data_transfer_i=0 SHALL pop head, stay RESP.
REQ-023 RESP: CR handshake with cr_data_transfer_i=1 SHALL move to DATA, no pop.
REQ-024 DATA: CD handshake with cd_last_i=1 SHALL pop head, return RESP; non-last beats no effect.
REQ-025 CD handshake in RESP, or CR handshake in DATA, SHALL set err_o[p] and be ignored.
REQ-026 CR handshake with FIFO empty SHALL set err_o[p], no state change.
REQ-027 Pop SHALL register cm_x_req_o[p]=1 and cm_x_addr_o[p]=popped address for exactly the next cycle.
REQ-028 cm_x_req_o[p]=0 in all other cycles; cm_x_addr_o[p] holds last released value when idle.
REQ-029 Same-cycle push and pop SHALL both take effect; count unchanged; legal even when full (push accepted, ac_stall_o still 1 that cycle by REQ-019 and upstream gating).
REQ-030 Read/write pointers SHALL wrap modulo MaxSnoopTrans; count width $clog2(MaxSnoopTrans)+1.
REQ-031 Ports SHALL be fully independent; pulses on several ports in one cycle allowed.

Reset
REQ-032 rst_ni low SHALL asynchronously clear FIFOs, pointers, counts, FSMs (RESP), err_o, cm_x_req_o, cm_x_addr_o to 0.
REQ-033 Reset mid-transaction SHALL discard all outstanding entries without emitting release pulses.
REQ-034 Outputs after reset: ac_stall_o=0, cm_x_req_o=0, err_o=0.

Verification
REQ-035 Port 0 AC addr 0x1040, then CR dt=0 -> one cycle after CR, cm_x_req_o[0]=1, cm_x_addr_o[0]=0x41.
REQ-036 AC 0x80, CR dt=1, CD 4 beats last on 4th -> single pulse with addr 0x2 only after 4th beat.
REQ-037 Four ACs (depth 4) -> ac_stall_o[0]=1; same-cycle CR pop + AC push -> count stays 4, pulses return addresses in push order.
REQ-038 CR with empty FIFO, and CD in RESP -> err_o[p]=1 and stays 1 until reset; no pulse.
REQ-039 Ports 0 and 1 complete in same cycle -> cm_x_req_o=2'b11 with correct per-port addresses.
REQ-040 Assert rst_ni low with 3 entries outstanding -> all outputs 0 immediately; later CR flags err_o, no pulse.
